// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_pkg
// Description : Shared RV32I memory-stage codes, M/W register layout and
//               byte-enable helper.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_pkg;

    // Load/store size-sign select (funct3 encoding)
    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    // Write-back source select (11 falls back to the ALU result)
    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    // M/W pipeline register contents
    typedef struct packed {
        logic [31:0] alu_data;
        logic [31:0] ld_data;
        logic [31:0] pc_4;
        logic [1:0]  wb_sel;
        logic [4:0]  rd_addr;
        logic        rd_wren;
        logic        ins_n_vld;
    } mw_reg_t;

    // Byte enables for a store; unknown size codes act as a full word
    function automatic logic [3:0] ls_byte_en(input logic [2:0] slt_sl,
                                              input logic [1:0] lane);
        logic [3:0] be;
        case (slt_sl)
            LS_B:    be = 4'b0001 << lane;
            LS_H:    be = lane[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage
`default_nettype wire

// File: rtl/memory_cycle_if.sv
`default_nettype none
// ============================================================================
// Module      : memory_cycle_if
// Description : Execute-to-memory pipeline bundle plus the W-side results.
// Revision    : 1.0 - initial release
// ============================================================================
interface memory_cycle_if;

    logic        i_rst_M;
    logic        i_enb_M;
    logic        i_ins_n_vld_M;
    logic [31:0] i_pc_4_M;
    logic [31:0] i_alu_data_M;
    logic [2:0]  i_slt_sl_M;
    logic        i_rd_wren_M;
    logic        i_mem_wren_M;
    logic [1:0]  i_wb_sel_M;
    logic [31:0] i_rs2_data_M;
    logic [4:0]  i_rd_addr_M;
    logic [31:0] o_ld_data_M;
    logic [31:0] o_rs_W;
    logic [4:0]  o_rd_addr_W;
    logic        o_rd_wren_W;
    logic        o_ins_n_vld_W;

    // Execute side: drives the M-stage inputs, observes the results
    modport master (
        output i_rst_M, i_enb_M, i_ins_n_vld_M, i_pc_4_M, i_alu_data_M,
               i_slt_sl_M, i_rd_wren_M, i_mem_wren_M, i_wb_sel_M,
               i_rs2_data_M, i_rd_addr_M,
        input  o_ld_data_M, o_rs_W, o_rd_addr_W, o_rd_wren_W, o_ins_n_vld_W
    );

    // Memory stage
    modport slave (
        input  i_rst_M, i_enb_M, i_ins_n_vld_M, i_pc_4_M, i_alu_data_M,
               i_slt_sl_M, i_rd_wren_M, i_mem_wren_M, i_wb_sel_M,
               i_rs2_data_M, i_rd_addr_M,
        output o_ld_data_M, o_rs_W, o_rd_addr_W, o_rd_wren_W, o_ins_n_vld_W
    );

endinterface
`default_nettype wire

// File: rtl/memory_cycle_data_mem.sv
`default_nettype none
// ============================================================================
// Module      : data_mem
// Description : Word-organised data RAM, byte-enable synchronous write,
//               asynchronous read. Contents are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem #(
    parameter int DMEM_WORDS = 2048,
    parameter int ADDR_W     = $clog2(DMEM_WORDS)
) (
    input  wire logic              i_clk,
    input  wire logic              i_we,
    input  wire logic [3:0]        i_be,
    input  wire logic [ADDR_W-1:0] i_addr,
    input  wire logic [31:0]       i_wdata,
    output logic      [31:0]       o_rdata
);

    logic [31:0] mem [DMEM_WORDS];

    // Byte-lane write of the addressed word
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_be[b]) begin
                    mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

    assign o_rdata = mem[i_addr];

endmodule
`default_nettype wire

// File: rtl/memory_cycle.sv
`default_nettype none
// ============================================================================
// Module      : memory_cycle
// Description : RV32I memory-access stage: load/store against internal data
//               memory, M/W pipeline register and write-back select.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_cycle
    import rv_pkg::*;
#(
    parameter int DMEM_WORDS = 2048,
    parameter int ADDR_W     = $clog2(DMEM_WORDS)
) (
    input  wire logic     i_clk,
    input  wire logic     i_rst,
    memory_cycle_if.slave bus
);

    logic [ADDR_W-1:0] w_word_idx;
    logic [1:0]        w_lane;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic              w_we;
    logic [31:0]       w_rdata;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_ld_data;
    mw_reg_t           mw_d;
    mw_reg_t           mw_q;

    // Upper address bits wrap the memory; they are intentionally dropped
    logic w_unused_addr;
    assign w_unused_addr = ^bus.i_alu_data_M[31:ADDR_W+2];

    assign w_word_idx = bus.i_alu_data_M[ADDR_W+1:2];
    assign w_lane     = bus.i_alu_data_M[1:0];
    assign w_be       = ls_byte_en(bus.i_slt_sl_M, w_lane);

    // Flush, reset and stall all block the write, so each store lands once
    assign w_we = bus.i_mem_wren_M & ~bus.i_enb_M & ~i_rst & ~bus.i_rst_M;

    // Replicate store data so every enabled lane sees the right bytes
    always_comb begin
        w_wdata = bus.i_rs2_data_M;
        case (bus.i_slt_sl_M)
            LS_B:    w_wdata = {4{bus.i_rs2_data_M[7:0]}};
            LS_H:    w_wdata = {2{bus.i_rs2_data_M[15:0]}};
            default: w_wdata = bus.i_rs2_data_M;
        endcase
    end

    data_mem #(
        .DMEM_WORDS (DMEM_WORDS),
        .ADDR_W     (ADDR_W)
    ) u_data_mem (
        .i_clk   (i_clk),
        .i_we    (w_we),
        .i_be    (w_be),
        .i_addr  (w_word_idx),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata)
    );

    // Lane extraction and sign/zero extension of the loaded word
    always_comb begin
        w_byte    = w_rdata[w_lane*8 +: 8];
        w_half    = w_lane[1] ? w_rdata[31:16] : w_rdata[15:0];
        w_ld_data = w_rdata;
        case (bus.i_slt_sl_M)
            LS_B:    w_ld_data = {{24{w_byte[7]}}, w_byte};
            LS_H:    w_ld_data = {{16{w_half[15]}}, w_half};
            LS_BU:   w_ld_data = {24'h0, w_byte};
            LS_HU:   w_ld_data = {16'h0, w_half};
            default: w_ld_data = w_rdata;
        endcase
    end

    assign bus.o_ld_data_M = w_ld_data;

    // Next M/W contents: hold while stalled, otherwise capture the M stage
    always_comb begin
        mw_d = mw_q;
        if (!bus.i_enb_M) begin
            mw_d.alu_data  = bus.i_alu_data_M;
            mw_d.ld_data   = w_ld_data;
            mw_d.pc_4      = bus.i_pc_4_M;
            mw_d.wb_sel    = bus.i_wb_sel_M;
            mw_d.rd_addr   = bus.i_rd_addr_M;
            mw_d.rd_wren   = bus.i_rd_wren_M;
            mw_d.ins_n_vld = bus.i_ins_n_vld_M;
        end
    end

    // M/W register; reset and flush override the stall
    always_ff @(posedge i_clk) begin
        if (i_rst || bus.i_rst_M) begin
            mw_q <= '0;
        end else begin
            mw_q <= mw_d;
        end
    end

    // Write-back source select
    always_comb begin
        case (mw_q.wb_sel)
            WB_MEM:  bus.o_rs_W = mw_q.ld_data;
            WB_PC4:  bus.o_rs_W = mw_q.pc_4;
            default: bus.o_rs_W = mw_q.alu_data;
        endcase
    end

    assign bus.o_rd_addr_W   = mw_q.rd_addr;
    assign bus.o_rd_wren_W   = mw_q.rd_wren;
    assign bus.o_ins_n_vld_W = mw_q.ins_n_vld;

endmodule
`default_nettype wire

// File: tb/tb_memory_cycle.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_cycle
// Description : Directed self-checking bench for the memory-access stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_cycle;
    import rv_pkg::*;

    localparam int C_WORDS = 2048;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    memory_cycle_if bus ();

    memory_cycle #(
        .DMEM_WORDS (C_WORDS)
    ) u_dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive one M-stage instruction
    task automatic drive(input logic enb, input logic rstm, input logic wren,
                         input logic [1:0] wb, input logic [2:0] slt,
                         input logic [31:0] alu, input logic [31:0] rs2,
                         input logic [4:0] rd, input logic rdw,
                         input logic [31:0] pc4, input logic nvld);
        bus.i_enb_M       = enb;
        bus.i_rst_M       = rstm;
        bus.i_mem_wren_M  = wren;
        bus.i_wb_sel_M    = wb;
        bus.i_slt_sl_M    = slt;
        bus.i_alu_data_M  = alu;
        bus.i_rs2_data_M  = rs2;
        bus.i_rd_addr_M   = rd;
        bus.i_rd_wren_M   = rdw;
        bus.i_pc_4_M      = pc4;
        bus.i_ins_n_vld_M = nvld;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, WB_ALU, LS_W, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic store(input logic [2:0] slt, input logic [31:0] addr,
                         input logic [31:0] data);
        drive(1'b0, 1'b0, 1'b1, WB_ALU, slt, addr, data, 5'd0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic load(input logic [2:0] slt, input logic [31:0] addr,
                        input logic [4:0] rd);
        drive(1'b0, 1'b0, 1'b0, WB_MEM, slt, addr, 32'h0, rd, 1'b1, 32'h0, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        // A live instruction during reset must not leak through
        drive(1'b0, 1'b0, 1'b0, WB_PC4, LS_W, 32'h40, 32'h0, 5'd3, 1'b1, 32'h44, 1'b1);
        tick();
        tick();
        chk("rst_rs_W",       bus.o_rs_W,                 32'h0);
        chk("rst_rd_addr",    {27'h0, bus.o_rd_addr_W},   32'h0);
        chk("rst_rd_wren",    {31'h0, bus.o_rd_wren_W},   32'h0);
        chk("rst_ins_n_vld",  {31'h0, bus.o_ins_n_vld_W}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // SW then LW, including the one-cycle write-back latency
        store(LS_W, 32'h100, 32'hDEADBEEF);
        tick();
        load(LS_W, 32'h100, 5'd5);
        chk("lw_ld_data", bus.o_ld_data_M, 32'hDEADBEEF);
        tick();
        chk("lw_rs_W",   bus.o_rs_W,               32'hDEADBEEF);
        chk("lw_rd",     {27'h0, bus.o_rd_addr_W}, 32'd5);
        chk("lw_rd_wren", {31'h0, bus.o_rd_wren_W}, 32'd1);

        // Byte store into lane 3, signed/unsigned byte loads
        store(LS_B, 32'h103, 32'h12345680);
        tick();
        load(LS_B, 32'h103, 5'd6);
        chk("lb",  bus.o_ld_data_M, 32'hFFFFFF80);
        load(LS_BU, 32'h103, 5'd6);
        chk("lbu", bus.o_ld_data_M, 32'h00000080);
        load(LS_W, 32'h100, 5'd6);
        chk("lw_after_sb", bus.o_ld_data_M, 32'h80ADBEEF);

        // Half store into upper half, lower half must survive
        store(LS_H, 32'h102, 32'hFFFF8001);
        tick();
        load(LS_H, 32'h102, 5'd7);
        chk("lh",  bus.o_ld_data_M, 32'hFFFF8001);
        load(LS_HU, 32'h102, 5'd7);
        chk("lhu", bus.o_ld_data_M, 32'h00008001);
        load(LS_W, 32'h100, 5'd7);
        chk("lw_after_sh", bus.o_ld_data_M, 32'h8001BEEF);
        load(LS_BU, 32'h101, 5'd7);
        chk("lbu_lane1", bus.o_ld_data_M, 32'h000000BE);

        // Stall with a pending store: no write, W outputs hold
        store(LS_W, 32'h300, 32'h0);
        tick();
        drive(1'b0, 1'b0, 1'b0, WB_ALU, LS_W, 32'h11, 32'h0, 5'd7, 1'b1, 32'h0, 1'b1);
        tick();
        chk("pre_stall_rs_W", bus.o_rs_W, 32'h11);
        chk("pre_stall_nvld", {31'h0, bus.o_ins_n_vld_W}, 32'd1);
        drive(1'b1, 1'b0, 1'b1, WB_ALU, LS_W, 32'h300, 32'hCAFEF00D, 5'd9, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_rs_W",   bus.o_rs_W,               32'h11);
            chk("stall_rd",     {27'h0, bus.o_rd_addr_W}, 32'd7);
            chk("stall_no_wr",  bus.o_ld_data_M,          32'h0);
        end
        bus.i_enb_M = 1'b0;
        #1;
        tick();
        chk("release_wr",   bus.o_ld_data_M,          32'hCAFEF00D);
        chk("release_rs_W", bus.o_rs_W,               32'h300);
        chk("release_rd",   {27'h0, bus.o_rd_addr_W}, 32'd9);

        // Flush during a store: suppressed write and a bubble in W
        store(LS_W, 32'h200, 32'h12345678);
        tick();
        drive(1'b0, 1'b1, 1'b1, WB_ALU, LS_W, 32'h200, 32'h55, 5'd3, 1'b1, 32'h0, 1'b1);
        tick();
        chk("flush_rd_wren", {31'h0, bus.o_rd_wren_W}, 32'd0);
        chk("flush_rs_W",    bus.o_rs_W,               32'h0);
        chk("flush_rd",      {27'h0, bus.o_rd_addr_W}, 32'd0);
        load(LS_W, 32'h200, 5'd4);
        chk("flush_no_wr", bus.o_ld_data_M, 32'h12345678);

        // PC+4 write-back and the 11 fallback to ALU
        drive(1'b0, 1'b0, 1'b0, WB_PC4, LS_W, 32'h77, 32'h0, 5'd1, 1'b1, 32'h1004, 1'b0);
        tick();
        chk("wb_pc4", bus.o_rs_W, 32'h1004);
        drive(1'b0, 1'b0, 1'b0, 2'b11, LS_W, 32'h88, 32'h0, 5'd1, 1'b1, 32'h1008, 1'b0);
        tick();
        chk("wb_11_alu", bus.o_rs_W, 32'h88);

        // Address aliasing past the top of memory
        store(LS_W, 32'(4 * C_WORDS + 32'h10), 32'hA5A5A5A5);
        tick();
        load(LS_W, 32'h10, 5'd2);
        chk("alias", bus.o_ld_data_M, 32'hA5A5A5A5);

        // Reset mid-stream clears W but keeps memory
        load(LS_W, 32'h100, 5'd8);
        tick();
        chk("pre_rst_rs_W", bus.o_rs_W, 32'h8001BEEF);
        rst = 1'b1;
        tick();
        chk("mid_rst_rs_W", bus.o_rs_W,               32'h0);
        chk("mid_rst_rd",   {27'h0, bus.o_rd_addr_W}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        load(LS_W, 32'h100, 5'd8);
        chk("mem_retained", bus.o_ld_data_M, 32'h8001BEEF);
        idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
